// File: rtl/mic_i2s_capture_ctrl.sv
// I2S master capture for a PCM MEMS microphone: generates BCLK/LRCLK, shifts in
// one channel slot per frame and presents it on a valid/ready handshake.
module mic_i2s_capture_ctrl #(
  parameter int unsigned DIV      = 12,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned SAMPLE_W = 18,
  parameter int unsigned CHANNEL  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mic_sd,
  output logic                bclk,
  output logic                lrclk,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned FRAME_W = 2 * SLOT_W;
  localparam int unsigned FB_W    = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned BASE    = CHANNEL * SLOT_W;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
  localparam logic [FB_W-1:0]  WIN_LO     = FB_W'(BASE + 1);
  localparam logic [FB_W-1:0]  WIN_HI     = FB_W'(BASE + SAMPLE_W);
  localparam logic [FB_W-1:0]  FB_LAST    = FB_W'(FRAME_W - 1);
  localparam logic [FB_W-1:0]  SLOT_START = FB_W'(SLOT_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FB_W-1:0]     fb_q, fb_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;

  logic                tick;
  logic                rise_ev;
  logic                fall_ev;
  logic                load;
  logic [FB_W-1:0]     fb_next;

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_RELOAD;
      fb_q      <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      shift_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fb_q      <= fb_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, clock generation, capture and handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fb_d      = fb_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    tick      = (cnt_q == '0);
    rise_ev   = 1'b0;
    fall_ev   = 1'b0;
    load      = 1'b0;
    fb_next   = (fb_q == FB_LAST) ? '0 : fb_q + FB_W'(1);

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        cnt_d   = CNT_RELOAD;
        fb_d    = '0;
        if (enable) begin
          state_d   = S_RUN;
          overrun_d = 1'b0;
        end
      end
      S_RUN, S_STOP: begin
        rise_ev = tick && !bclk_q;
        fall_ev = tick && bclk_q;
        if (tick) begin
          bclk_d = !bclk_q;
          cnt_d  = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (rise_ev && (fb_q >= WIN_LO) && (fb_q <= WIN_HI)) begin
          shift_d = SAMPLE_W'({shift_q, mic_sd});
        end
        load = rise_ev && (fb_q == WIN_HI);
        if (fall_ev) begin
          fb_d    = fb_next;
          lrclk_d = (fb_next >= SLOT_START);
        end
        if (state_q == S_RUN) begin
          if (!enable) begin
            state_d = S_STOP;
          end
        end else if (enable) begin
          state_d = S_RUN;
        end else if (fall_ev && (fb_next == '0)) begin
          // Stop only on the frame boundary so the mic never sees a short frame
          state_d = S_IDLE;
          bclk_d  = 1'b0;
          lrclk_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A load beats a same-cycle accept; an unread sample being replaced is an overrun
    if (load) begin
      sample_d = SAMPLE_W'({shift_q, mic_sd});
      valid_d  = 1'b1;
      if (valid_q && !sample_ready) begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mic_i2s_capture_ctrl.sv
// Directed bench for mic_i2s_capture_ctrl: a bench-side mic model drives serial
// data, expected samples go through a scoreboard queue.
module tb_mic_i2s_capture_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en0, en1, en2;
  logic       ready;
  logic [7:0] lw, rw;
  int         sel;

  logic       sd0, sd1, sd2;
  logic       bclk0, bclk1, bclk2;
  logic       lr0, lr1, lr2;
  logic [7:0] smp0, smp1, smp2;
  logic       vld0, vld1, vld2;
  logic       ovr0, ovr1, ovr2;
  logic       busy0, busy1, busy2;
  logic [4:0] fb0 = '0;
  logic [4:0] fb1 = '0;
  logic [4:0] fb2 = '0;

  logic       obs_bclk, obs_lr, obs_vld, obs_ovr, obs_busy;
  logic [7:0] obs_smp;
  logic [4:0] obs_fb;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mic_i2s_capture_ctrl #(.DIV(2), .SLOT_W(16), .SAMPLE_W(8), .CHANNEL(0)) u_ch0 (
    .clk(clk), .reset(reset), .enable(en0), .mic_sd(sd0), .bclk(bclk0), .lrclk(lr0),
    .sample(smp0), .sample_valid(vld0), .sample_ready(ready), .overrun(ovr0), .busy(busy0));

  mic_i2s_capture_ctrl #(.DIV(2), .SLOT_W(16), .SAMPLE_W(8), .CHANNEL(1)) u_ch1 (
    .clk(clk), .reset(reset), .enable(en1), .mic_sd(sd1), .bclk(bclk1), .lrclk(lr1),
    .sample(smp1), .sample_valid(vld1), .sample_ready(ready), .overrun(ovr1), .busy(busy1));

  mic_i2s_capture_ctrl #(.DIV(1), .SLOT_W(16), .SAMPLE_W(8), .CHANNEL(0)) u_div1 (
    .clk(clk), .reset(reset), .enable(en2), .mic_sd(sd2), .bclk(bclk2), .lrclk(lr2),
    .sample(smp2), .sample_valid(vld2), .sample_ready(ready), .overrun(ovr2), .busy(busy2));

  // Mic model: frame bit index advances on every BCLK fall, like the real part
  always @(negedge bclk0 or posedge reset) if (reset) fb0 <= '0; else fb0 <= fb0 + 5'd1;
  always @(negedge bclk1 or posedge reset) if (reset) fb1 <= '0; else fb1 <= fb1 + 5'd1;
  always @(negedge bclk2 or posedge reset) if (reset) fb2 <= '0; else fb2 <= fb2 + 5'd1;

  function automatic logic mic_bit(input logic [4:0] fb, input logic [7:0] l, input logic [7:0] r);
    logic b;
    b = 1'b1;
    if (fb >= 5'd1 && fb <= 5'd8) b = l[3'(5'd8 - fb)];
    else if (fb >= 5'd17 && fb <= 5'd24) b = r[3'(5'd24 - fb)];
    return b;
  endfunction

  assign sd0 = mic_bit(fb0, lw, rw);
  assign sd1 = mic_bit(fb1, lw, rw);
  assign sd2 = mic_bit(fb2, lw, rw);

  assign obs_bclk = (sel == 0) ? bclk0 : (sel == 1) ? bclk1 : bclk2;
  assign obs_lr   = (sel == 0) ? lr0   : (sel == 1) ? lr1   : lr2;
  assign obs_vld  = (sel == 0) ? vld0  : (sel == 1) ? vld1  : vld2;
  assign obs_ovr  = (sel == 0) ? ovr0  : (sel == 1) ? ovr1  : ovr2;
  assign obs_busy = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  assign obs_smp  = (sel == 0) ? smp0  : (sel == 1) ? smp1  : smp2;
  assign obs_fb   = (sel == 0) ? fb0   : (sel == 1) ? fb1   : fb2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic pick(input int what);
    case (what)
      0:       return obs_vld;
      1:       return obs_busy;
      2:       return obs_lr;
      3:       return obs_bclk;
      default: return obs_ovr;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int what, input logic val, input int max,
                          output int waited);
    waited = 0;
    while (pick(what) !== val && waited < max) begin
      @(negedge clk);
      waited++;
    end
    chk(tag, 32'(pick(what)), 32'(val));
  endtask

  task automatic wait_fb(input string tag, input logic [4:0] val, input int max);
    int waited;
    waited = 0;
    while (obs_fb !== val && waited < max) begin
      @(negedge clk);
      waited++;
    end
    chk(tag, 32'(obs_fb), 32'(val));
  endtask

  task automatic expect_sample(input string tag, input int max);
    int w;
    logic [7:0] e;
    wait_for({tag, "_valid"}, 0, 1'b1, max, w);
    e = exp_q.pop_front();
    chk(tag, 32'(obs_smp), 32'(e));
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_bclk"},    32'(obs_bclk), 32'd0);
    chk({pfx, "_lrclk"},   32'(obs_lr),   32'd0);
    chk({pfx, "_sample"},  32'(obs_smp),  32'd0);
    chk({pfx, "_valid"},   32'(obs_vld),  32'd0);
    chk({pfx, "_overrun"}, 32'(obs_ovr),  32'd0);
    chk({pfx, "_busy"},    32'(obs_busy), 32'd0);
  endtask

  initial begin
    int w, w2, n, rises;
    logic prev;
    reset = 1'b1; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; ready = 1'b0;
    lw = 8'hA5; rw = 8'hFF; sel = 0;
    cyc(3);
    chk_reset("rst");
    reset = 1'b0;
    cyc(1);

    // Basic capture, clock timing, handshake
    exp_q.push_back(8'hA5);
    en0 = 1'b1;
    cyc(1);
    chk("busy_run", 32'(obs_busy), 32'd1);
    wait_for("first_rise", 3, 1'b1, 10, w);
    chk("first_rise_lat", 32'(w), 32'd2);
    wait_for("bclk_fall", 3, 1'b0, 10, w);
    wait_for("bclk_rise2", 3, 1'b1, 10, w2);
    chk("bclk_period", 32'(w + w2), 32'd4);
    expect_sample("a5", 200);
    chk("a5_lrclk", 32'(obs_lr), 32'd0);
    cyc(1);
    chk("valid_hold", 32'(obs_vld), 32'd1);
    ready = 1'b1;
    cyc(1);
    chk("valid_clear", 32'(obs_vld), 32'd0);
    chk("no_overrun", 32'(obs_ovr), 32'd0);
    wait_for("lr_hi", 2, 1'b1, 200, w);
    chk("lr_on_fall", 32'(obs_bclk), 32'd0);
    wait_for("lr_lo", 2, 1'b0, 100, w);
    chk("lr_half_lo", 32'(w), 32'd64);
    wait_for("lr_hi2", 2, 1'b1, 100, w);
    chk("lr_half_hi", 32'(w), 32'd64);

    // Overrun: leave two samples unread
    ready = 1'b0;
    exp_q.push_back(8'hA5);
    expect_sample("ovr_first", 200);
    lw = 8'h5A;
    exp_q.push_back(8'h5A);
    wait_for("ovr_set", 4, 1'b1, 200, w);
    chk("ovr_sample", 32'(obs_smp), 32'(exp_q.pop_front()));
    chk("ovr_valid", 32'(obs_vld), 32'd1);
    en0 = 1'b0;
    wait_for("stop_idle", 1, 1'b0, 300, w);
    chk("ovr_sticky", 32'(obs_ovr), 32'd1);
    lw = 8'hA5;
    en0 = 1'b1;
    cyc(1);
    chk("ovr_clear", 32'(obs_ovr), 32'd0);
    ready = 1'b1;

    // Stop request withdrawn before the frame ends
    wait_fb("fb20", 5'd20, 200);
    en0 = 1'b0;
    wait_fb("fb28", 5'd28, 100);
    en0 = 1'b1;
    wait_fb("fb_past_wrap", 5'd1, 100);
    chk("reassert_busy", 32'(obs_busy), 32'd1);

    // Stop lands on the frame boundary
    wait_fb("fb20b", 5'd20, 200);
    en0 = 1'b0;
    w = 0; rises = 0; prev = obs_bclk;
    while (obs_busy === 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
      if (obs_bclk && !prev) rises++;
      prev = obs_bclk;
    end
    chk("stop_cycles", 32'(w), 32'd48);
    chk("stop_rises", 32'(rises), 32'd12);
    chk("stop_bclk", 32'(obs_bclk), 32'd0);
    chk("stop_lrclk", 32'(obs_lr), 32'd0);
    chk("stop_fb", 32'(obs_fb), 32'd0);

    // Reset mid-frame
    ready = 1'b0;
    en0 = 1'b1;
    cyc(1);
    wait_fb("fb5", 5'd5, 100);
    reset = 1'b1;
    en0 = 1'b0;
    cyc(1);
    chk_reset("midrst");
    cyc(2);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (obs_vld === 1'b1) n++;
    end
    chk("no_partial", 32'(n), 32'd0);

    // Right channel only
    sel = 1; lw = 8'hFF; rw = 8'h3C; ready = 1'b1;
    exp_q.push_back(8'h3C);
    en1 = 1'b1;
    expect_sample("ch1_first", 300);
    chk("ch1_slot", 32'(obs_lr), 32'd1);
    n = 0;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      if (obs_vld === 1'b1) begin
        n++;
        chk("ch1_each", 32'(obs_smp), 32'h3C);
      end
    end
    chk("ch1_per_frame", 32'(n), 32'd2);
    en1 = 1'b0;
    wait_for("ch1_idle", 1, 1'b0, 300, w);

    // DIV=1
    sel = 2; lw = 8'hA5; rw = 8'hFF;
    exp_q.push_back(8'hA5);
    en2 = 1'b1;
    cyc(1);
    wait_for("div1_rise", 3, 1'b1, 10, w);
    chk("div1_rise_lat", 32'(w), 32'd1);
    prev = obs_bclk;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("div1_toggle", 32'(obs_bclk), 32'(!prev));
      prev = obs_bclk;
    end
    expect_sample("div1_a5", 100);
    en2 = 1'b0;
    wait_for("div1_idle", 1, 1'b0, 200, w);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
